placement_cost_eval: RTL and testbench

//  Standalone stage that consumes the placement stage's result (the pos_X/pos_Y RAMs and the edge ROMs).
//  On start it walks all N_EDGE edges and reads both endpoint positions.
//  It accumulates total Manhattan wirelength and 1-hop cost, and reports the longest edge plus any illegal placement.
//  It sits after placement has asserted out=1 and replaces that stage's inline eval states in larger flows.

---
 rtl/placement_pkg.sv | 10 +
 rtl/edge_cost.sv | 24 ++
 rtl/placement_cost_eval.sv | 132 +++++++++++++
 tb/tb_placement_cost_eval.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/placement_pkg.sv
// placement_pkg: state encodings, word type and empty-position marker shared by placement and cost evaluation
package placement_pkg;
  localparam int W = 32;
  typedef logic [W-1:0] word_t;
  localparam word_t POS_EMPTY = '1;
  typedef enum logic [2:0] {S_IDLE, S_RD_E, S_RD_PA, S_RD_PB, S_DIFF, S_ACC, S_DONE} state_t;
  function automatic logic bad_coord(word_t v, int n);
    return v == POS_EMPTY || $signed(v) < 0 || $signed(v) >= n;
  endfunction
endpackage

// File: rtl/edge_cost.sv
// edge_cost: Manhattan length, 1-hop term and legality of one edge from its endpoint coordinates
module edge_cost import placement_pkg::*; #(
  parameter int N = 9
) (
  input  logic [31:0] xa,
  input  logic [31:0] ya,
  input  logic [31:0] xb,
  input  logic [31:0] yb,
  output logic [31:0] len,
  output logic [31:0] hop,
  output logic        illegal
);
  logic [31:0] ddx, ddy, dx, dy;
  always_comb begin
    ddx = xa - xb;
    ddy = ya - yb;
    dx = ddx[31] ? -ddx : ddx;
    dy = ddy[31] ? -ddy : ddy;
    len = dx + dy;
    hop = (dx >> 1) + {31'd0, dx[0]} + (dy >> 1) + {31'd0, dy[0]} - 32'd1;
    illegal = bad_coord(xa, N) | bad_coord(ya, N) | bad_coord(xb, N) | bad_coord(yb, N) |
              (dx == '0 && dy == '0);
  end
endmodule

// File: rtl/placement_cost_eval.sv
// placement_cost_eval: walks the edge list, fetches endpoint positions and accumulates wirelength costs
module placement_cost_eval import placement_pkg::*; #(
  parameter int N      = 9,
  parameter int N_EDGE = 88,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        re_ea,
  output logic        re_eb,
  output logic [31:0] addr_ea,
  output logic [31:0] addr_eb,
  input  logic [31:0] ea_data,
  input  logic [31:0] eb_data,
  output logic        re_px,
  output logic        re_py,
  output logic [31:0] addr_px,
  output logic [31:0] addr_py,
  input  logic [31:0] px_data,
  input  logic [31:0] py_data,
  output logic [31:0] sum,
  output logic [31:0] sum_1hop,
  output logic [31:0] max_len,
  output logic        err,
  output logic [31:0] err_cnt
);
  localparam int CW = $clog2(RD_LAT + 1);
  localparam logic [CW-1:0] C_LAST = CW'(RD_LAT - 1);
  state_t state;
  logic [CW-1:0] wcnt;
  logic [31:0] idx, b, xa, ya, xb, yb, len, hop, len_q, hop_q;
  logic ill, ill_q, last;
  assign last = wcnt == C_LAST;
  assign re_eb = re_ea;
  assign addr_eb = addr_ea;
  assign re_py = re_px;
  assign addr_py = addr_px;
  edge_cost #(.N(N)) u_cost (.xa(xa), .ya(ya), .xb(xb), .yb(yb), .len(len), .hop(hop), .illegal(ill));
  // Memory data is captured on the edge that enters the next phase; the follow-up read issues on that same edge.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      wcnt <= '0;
      idx <= '0;
      b <= '0;
      xa <= '0;
      ya <= '0;
      xb <= '0;
      yb <= '0;
      len_q <= '0;
      hop_q <= '0;
      ill_q <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      re_ea <= 1'b0;
      re_px <= 1'b0;
      addr_ea <= '0;
      addr_px <= '0;
      sum <= '0;
      sum_1hop <= '0;
      max_len <= '0;
      err <= 1'b0;
      err_cnt <= '0;
    end else begin
      re_ea <= 1'b0;
      re_px <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          sum <= '0;
          sum_1hop <= '0;
          max_len <= '0;
          err <= 1'b0;
          err_cnt <= '0;
          idx <= '0;
          wcnt <= '0;
          addr_ea <= '0;
          busy <= N_EDGE != 0;
          done <= N_EDGE == 0;
          re_ea <= N_EDGE != 0;
          state <= N_EDGE == 0 ? S_DONE : S_RD_E;
        end
        S_RD_E, S_RD_PA, S_RD_PB: begin
          wcnt <= last ? '0 : wcnt + 1'b1;
          if (last) begin
            re_px <= state != S_RD_PB;
            addr_px <= state == S_RD_E ? ea_data : b;
            if (state == S_RD_E) b <= eb_data;
            if (state == S_RD_PA) begin
              xa <= px_data;
              ya <= py_data;
            end
            if (state == S_RD_PB) begin
              xb <= px_data;
              yb <= py_data;
            end
            state <= state == S_RD_E ? S_RD_PA : state == S_RD_PA ? S_RD_PB : S_DIFF;
          end
        end
        S_DIFF: begin
          len_q <= len;
          hop_q <= hop;
          ill_q <= ill;
          state <= S_ACC;
        end
        S_ACC: begin
          if (ill_q) begin
            err <= 1'b1;
            err_cnt <= err_cnt + 1;
          end else begin
            sum <= sum + len_q - 32'd1;
            sum_1hop <= sum_1hop + hop_q;
            if (len_q > max_len) max_len <= len_q;
          end
          idx <= idx + 1;
          if (idx == 32'(N_EDGE - 1)) begin
            busy <= 1'b0;
            done <= 1'b1;
            state <= S_DONE;
          end else begin
            re_ea <= 1'b1;
            addr_ea <= idx + 1;
            state <= S_RD_E;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_placement_cost_eval.sv
// tb_placement_cost_eval: table-driven runs on 1-, 2- and 0-edge instances with a done-time scoreboard
module tb_placement_cost_eval;
  typedef struct {
    logic [31:0] s, h, m, c;
    logic e;
    int at;
  } exp_t;
  typedef struct {
    logic [3:0][31:0] x, y;
    logic [31:0] eb1;
    exp_t e1, e2;
  } vec_t;

  logic clk = 0, reset = 1, start = 0, start0 = 0;
  always #5 clk = ~clk;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic busy1, done1, re_ea1, re_eb1, re_px1, re_py1, err1;
  logic [31:0] addr_ea1, addr_eb1, addr_px1, addr_py1, ea1, eb1, px1, py1, sum1, hop1, max1, cnt1;
  logic busy2, done2, re_ea2, re_eb2, re_px2, re_py2, err2;
  logic [31:0] addr_ea2, addr_eb2, addr_px2, addr_py2, ea2, eb2, px2, py2, sum2, hop2, max2, cnt2;
  logic busy0, done0, re_ea0, re_eb0, re_px0, re_py0, err0;
  logic [31:0] addr_ea0, addr_eb0, addr_px0, addr_py0, sum0, hop0, max0, cnt0;

  placement_cost_eval #(.N(9), .N_EDGE(1), .RD_LAT(2)) d1 (.clk(clk), .reset(reset), .start(start),
    .busy(busy1), .done(done1), .re_ea(re_ea1), .re_eb(re_eb1), .addr_ea(addr_ea1), .addr_eb(addr_eb1),
    .ea_data(ea1), .eb_data(eb1), .re_px(re_px1), .re_py(re_py1), .addr_px(addr_px1), .addr_py(addr_py1),
    .px_data(px1), .py_data(py1), .sum(sum1), .sum_1hop(hop1), .max_len(max1), .err(err1), .err_cnt(cnt1));
  placement_cost_eval #(.N(9), .N_EDGE(2), .RD_LAT(2)) d2 (.clk(clk), .reset(reset), .start(start),
    .busy(busy2), .done(done2), .re_ea(re_ea2), .re_eb(re_eb2), .addr_ea(addr_ea2), .addr_eb(addr_eb2),
    .ea_data(ea2), .eb_data(eb2), .re_px(re_px2), .re_py(re_py2), .addr_px(addr_px2), .addr_py(addr_py2),
    .px_data(px2), .py_data(py2), .sum(sum2), .sum_1hop(hop2), .max_len(max2), .err(err2), .err_cnt(cnt2));
  placement_cost_eval #(.N(9), .N_EDGE(0), .RD_LAT(2)) d0 (.clk(clk), .reset(reset), .start(start0),
    .busy(busy0), .done(done0), .re_ea(re_ea0), .re_eb(re_eb0), .addr_ea(addr_ea0), .addr_eb(addr_eb0),
    .ea_data(32'd0), .eb_data(32'd0), .re_px(re_px0), .re_py(re_py0), .addr_px(addr_px0), .addr_py(addr_py0),
    .px_data(32'd0), .py_data(32'd0), .sum(sum0), .sum_1hop(hop0), .max_len(max0), .err(err0), .err_cnt(cnt0));

  // Memory models: read enable in cycle c, data valid through cycle c+1, captured by the DUT entering c+2.
  logic [31:0] rom_a [2], rom_b [2], mpx [4], mpy [4];
  always @(posedge clk) begin
    if (re_ea1) ea1 <= rom_a[addr_ea1[0]];
    if (re_eb1) eb1 <= rom_b[addr_eb1[0]];
    if (re_px1) px1 <= mpx[addr_px1[1:0]];
    if (re_py1) py1 <= mpy[addr_py1[1:0]];
    if (re_ea2) ea2 <= rom_a[addr_ea2[0]];
    if (re_eb2) eb2 <= rom_b[addr_eb2[0]];
    if (re_px2) px2 <= mpx[addr_px2[1:0]];
    if (re_py2) py2 <= mpy[addr_py2[1:0]];
  end

  exp_t q1[$], q2[$];
  bit re0_seen = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, $signed(act), $signed(want));
    end
  endtask

  task automatic score(string tag, exp_t e, logic [31:0] s, logic [31:0] h, logic [31:0] m,
                       logic [31:0] c, logic er);
    chk({tag, "_sum"}, s, e.s);
    chk({tag, "_sum_1hop"}, h, e.h);
    chk({tag, "_max_len"}, m, e.m);
    chk({tag, "_err"}, 32'(er), 32'(e.e));
    chk({tag, "_err_cnt"}, c, e.c);
    chk({tag, "_done_cycle"}, cyc, e.at);
  endtask

  always @(negedge clk) begin
    if (re_ea0 | re_eb0 | re_px0 | re_py0) re0_seen = 1;
    if (done1) begin
      if (q1.size() > 0) score("d1", q1.pop_front(), sum1, hop1, max1, cnt1, err1);
      else chk("d1_pending_results", q1.size(), 1);
    end
    if (done2) begin
      if (q2.size() > 0) score("d2", q2.pop_front(), sum2, hop2, max2, cnt2, err2);
      else chk("d2_pending_results", q2.size(), 1);
    end
  end

  function automatic exp_t mk_exp(int s, int h, int m, int e, int c);
    exp_t r;
    r.s = s; r.h = h; r.m = m; r.e = e[0]; r.c = c; r.at = 0;
    return r;
  endfunction

  function automatic vec_t mk(int x0, int y0, int x1, int y1, int x2, int y2, int x3, int y3, int eb,
                              int s1, int h1, int m1, int e1, int c1, int s2, int h2, int m2, int e2, int c2);
    vec_t v;
    v.x[0] = x0; v.y[0] = y0; v.x[1] = x1; v.y[1] = y1;
    v.x[2] = x2; v.y[2] = y2; v.x[3] = x3; v.y[3] = y3;
    v.eb1 = eb;
    v.e1 = mk_exp(s1, h1, m1, e1, c1);
    v.e2 = mk_exp(s2, h2, m2, e2, c2);
    return v;
  endfunction

  task automatic load_mem(vec_t v);
    rom_a[0] = 0; rom_b[0] = 1; rom_a[1] = 2; rom_b[1] = v.eb1;
    for (int i = 0; i < 4; i++) begin
      mpx[i] = v.x[i];
      mpy[i] = v.y[i];
    end
  endtask

  task automatic run_vec(vec_t v, bit repulse);
    exp_t e1, e2;
    load_mem(v);
    @(posedge clk); #1 start = 1;
    e1 = v.e1; e1.at = cyc + 9; q1.push_back(e1);
    e2 = v.e2; e2.at = cyc + 17; q2.push_back(e2);
    @(posedge clk); #1 start = 0;
    chk("busy_after_accept", 32'(busy2), 1);
    if (repulse) begin
      repeat (3) @(posedge clk);
      #1 start = 1;
      @(posedge clk); #1 start = 0;
    end
    for (int i = 0; i < 40 && (q1.size() + q2.size()) > 0; i++) @(posedge clk);
    if ((q1.size() + q2.size()) > 0) begin
      chk("done_timeout_pending", q1.size() + q2.size(), 0);
      q1.delete();
      q2.delete();
    end
    @(negedge clk);
    chk("done_one_cycle", 32'(done2), 0);
    chk("busy_after_done", 32'(busy2), 0);
  endtask

  vec_t vecs [7];
  initial begin
    int c0, dc;
    exp_t e;
    vecs[0] = mk(2,3, 5,1, 4,4, 4,5, 3,   4,2,5,0,0,   4,2,5,0,0);
    vecs[1] = mk(2,3, 5,1, 2,3, -1,1, 3,  4,2,5,0,0,   4,2,5,1,1);
    vecs[2] = mk(7,7, 7,7, 0,0, 8,8, 3,   0,0,0,1,1,   15,7,16,1,1);
    vecs[3] = mk(9,0, 0,0, 3,3, 1,1, 2,   0,0,0,1,1,   0,0,0,1,2);
    vecs[4] = mk(1,1, 2,2, 8,0, 0,7, 3,   1,1,2,0,0,   15,8,15,0,0);
    vecs[5] = mk(3,-5, 0,0, 0,8, 8,8, 3,  0,0,0,1,1,   7,3,8,1,1);
    vecs[6] = mk(0,0, 1,0, 2,9, 0,0, 3,   0,0,1,0,0,   0,0,1,1,1);
    #1 reset = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy2), 0);
    chk("rst_done", 32'(done2), 0);
    chk("rst_re", {re_ea2, re_eb2, re_px2, re_py2}, 0);
    chk("rst_addr_ea", addr_ea2, 0);
    chk("rst_addr_px", addr_px2, 0);
    chk("rst_sum", sum2, 0);
    chk("rst_sum_1hop", hop2, 0);
    chk("rst_max_len", max2, 0);
    chk("rst_err", 32'(err2), 0);
    chk("rst_err_cnt", cnt2, 0);
    reset = 1;
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i == 2);
    @(posedge clk); #1 start0 = 1; c0 = cyc;
    @(posedge clk); #1 start0 = 0;
    dc = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done0) begin
        dc = cyc;
        break;
      end
    end
    chk("d0_done_cycle", dc, c0 + 1);
    chk("d0_results", sum0 | hop0 | max0 | cnt0 | 32'(err0), 0);
    chk("d0_busy", 32'(busy0), 0);
    chk("d0_no_reads", 32'(re0_seen), 0);
    load_mem(vecs[0]);
    @(posedge clk); #1 start = 1;
    e = vecs[0].e1; e.at = cyc + 9; q1.push_back(e);
    @(posedge clk); #1 start = 0;
    repeat (11) @(posedge clk);
    #2;
    chk("pre_reset_sum", sum2, 4);
    chk("pre_reset_addr_ea", addr_ea2, 1);
    #1 reset = 0;
    #1;
    chk("midrun_rst_sum", sum2, 0);
    chk("midrun_rst_max_len", max2, 0);
    chk("midrun_rst_busy", 32'(busy2), 0);
    chk("midrun_rst_addr_ea", addr_ea2, 0);
    chk("d1_pending_after_reset", q1.size(), 0);
    q1.delete();
    q2.delete();
    @(posedge clk); #1 reset = 1;
    run_vec(vecs[4], 0);
    run_vec(vecs[1], 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t want end before 200000", $time);
    $fatal(1);
  end
endmodule
